// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
// onehot_to_idx mirrors what the downstream encoder does with gnt.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  // Lowest set bit index, or -1 when the vector is zero.
  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = -1;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set-bit search from index start, wrapping N-1 to 0.
// Purely combinational; output is one-hot or zero.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         pick
);

  int   idx;
  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: multi-hot req in, registered one-hot gnt out one cycle later.
// No backpressure; fairness comes from a rotating pointer plus an optional hold timeout.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         owner_changed
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  // Keep at least one bit of storage when the timeout is disabled.
  localparam int HW = (CW > 0) ? CW : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [N-1:0]  gnt_n;
  logic          chg_n;

  logic [PW-1:0] owner;
  logic [PW-1:0] owner_inc;
  logic [N-1:0]  others;
  logic [N-1:0]  pick_req;
  logic [PW-1:0] pick_start;
  logic [N-1:0]  pick;

  always_comb begin
    owner = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) owner = PW'(i);
    end
  end

  assign owner_inc  = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
  assign others     = req & ~gnt;
  assign pick_req   = (state == GRANT) ? others : req;
  assign pick_start = (state == GRANT) ? owner_inc : ptr;

  rr_pick #(.N(N)) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .pick  (pick)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    chg_n   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = pick;
          state_n = GRANT;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if ((req & gnt) == '0) begin
          // Release: hand straight to the next requester, no idle bubble.
          ptr_n  = owner_inc;
          hold_n = '0;
          if (|others) begin
            gnt_n = pick;
            chg_n = 1'b1;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          hold_n = '0;
          if (|others) begin
            gnt_n = pick;
            ptr_n = owner_inc;
            chg_n = 1'b1;
          end
        end else if (MAX_HOLD != 0 || hold_cnt != {HW{1'b1}}) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      gnt           <= '0;
      gnt_valid     <= 1'b0;
      owner_changed <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      hold_cnt      <= hold_n;
      gnt           <= gnt_n;
      gnt_valid     <= |gnt_n;
      owner_changed <= chg_n;
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
  a_req    : assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~$past(req)) == '0);

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus randomized req against a behavioural model.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int BOUND    = (N - 1) * MAX_HOLD + N;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         owner_changed;

  int n_chk;
  int n_fail;

  int m_own;
  int m_ptr;
  int m_hold;
  int m_chg;
  int waits [N];

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .gnt           (gnt),
    .gnt_valid     (gnt_valid),
    .owner_changed (owner_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_idx(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int m_gnt();
    return (m_own < 0) ? 0 : (1 << m_own);
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_ptr  = 0;
    m_hold = 0;
    m_chg  = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] rest;
    int nxt;
    m_chg = 0;
    if (m_own < 0) begin
      if (r != 0) begin
        m_own  = pick_idx(r, m_ptr);
        m_hold = 0;
      end
    end else begin
      rest = r;
      rest[m_own] = 1'b0;
      nxt = pick_idx(rest, (m_own + 1) % N);
      if (!r[m_own]) begin
        m_ptr  = (m_own + 1) % N;
        m_hold = 0;
        m_chg  = (nxt >= 0);
        m_own  = nxt;
      end else if (m_hold == MAX_HOLD - 1) begin
        m_hold = 0;
        if (nxt >= 0) begin
          m_ptr = (m_own + 1) % N;
          m_own = nxt;
          m_chg = 1;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  // Drive req for one cycle, advance the model on the edge, check just after it.
  task automatic cycle(input logic [N-1:0] r, input bit fair);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    chk("gnt", int'(gnt), m_gnt());
    chk("gnt_valid", int'(gnt_valid), int'(m_own >= 0));
    chk("owner_changed", int'(owner_changed), m_chg);
    chk("enc", onehot_to_idx(32'(gnt)), m_own);
    for (int i = 0; i < N; i++) begin
      if (r[i] && !gnt[i]) waits[i]++;
      else waits[i] = 0;
      if (fair) chk("fair_wait", int'(waits[i] > BOUND), 0);
    end
  endtask

  initial begin
    logic [N-1:0] r;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_chg", int'(owner_changed), 0);
    rst_n = 1'b1;

    repeat (5) cycle(4'b0000, 0);

    // Handoff from owner 1 to owner 3.
    cycle(4'b1010, 0);
    chk("first_grant", int'(gnt), 4'b0010);
    cycle(4'b1010, 0);
    cycle(4'b1000, 0);
    chk("handoff_gnt", int'(gnt), 4'b1000);
    chk("handoff_chg", int'(owner_changed), 1);
    cycle(4'b1000, 0);
    chk("chg_pulse", int'(owner_changed), 0);
    cycle(4'b0000, 0);
    chk("to_idle", int'(gnt_valid), 0);

    // All four requesting, each releasing after two granted cycles.
    cycle(4'b1111, 0);
    chk("rr_start", int'(gnt), 4'b0001);
    for (int e = 0; e < N; e++) begin
      cycle(4'b1111, 0);
      chk("rr_hold", int'(gnt), 1 << e);
      r = 4'b1111;
      r[e] = 1'b0;
      cycle(r, 0);
      chk("rr_next", int'(gnt), 1 << ((e + 1) % N));
      chk("rr_chg", int'(owner_changed), 1);
    end
    cycle(4'b0000, 0);

    // Steer the pointer back to 0, then exercise the hold timeout.
    cycle(4'b1000, 0);
    cycle(4'b0000, 0);
    for (int k = 0; k < MAX_HOLD; k++) begin
      cycle(4'b0011, 0);
      chk("timeout_hold", int'(gnt), 4'b0001);
    end
    cycle(4'b0011, 0);
    chk("timeout_gnt", int'(gnt), 4'b0010);
    chk("timeout_chg", int'(owner_changed), 1);
    cycle(4'b0000, 0);
    cycle(4'b0000, 0);

    // Sole requester keeps the grant through repeated timeouts.
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0100, 0);
      chk("sole_gnt", int'(gnt), 4'b0100);
      chk("sole_chg", int'(owner_changed), 0);
    end

    // Asynchronous reset mid-grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_valid", int'(gnt_valid), 0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random sticky requests.
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      end
      cycle(r, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that turns a multi-hot request vector into a registered one-hot grant vector.
- Sits directly upstream of the 4:2 encoder stage, which consumes `gnt` and produces the binary grantee index.
- Guarantees `gnt` is only ever all-zero or exactly one-hot, so the encoder never sees an illegal code.
- Enforces fairness with a rotating priority pointer and an optional maximum-hold timeout.

Parameters:
- N, 4: number of requesters; width of `req` and `gnt`; must be ≥2.
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant while others wait; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1): hold counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector; any number of bits may be high; bit i stays high while requester i wants or holds the resource.
- gnt  out  N  registered grant; all-zero or exactly one-hot.
- gnt_valid  out  1  registered; equals |gnt.
- owner_changed  out  1  registered one-cycle pulse on any edge where gnt changes from one nonzero value to a different nonzero value (handoff or preemption).

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_valid=0, owner_changed=0, state=IDLE, ptr=0 (req[0] highest priority), hold_cnt=0. Reset mid-grant drops gnt immediately and asynchronously.
- Pick function: first set bit of `req` searching cyclically from index `start` upward, wrapping N-1→0. Output is one-hot or zero.
- State IDLE:
  - req==0: stay in IDLE, gnt=0.
  - req!=0: next edge gnt=pick(req, ptr), state=GRANT, hold_cnt=0.
  - Latency from req to gnt is exactly 1 cycle.
- State GRANT, with owner = index of the set bit in gnt:
  - Release, req[owner]==0, others pending: next edge gnt=pick(req & ~(1<<owner), owner+1), owner_changed=1, hold_cnt=0. No idle bubble.
  - Release, no others pending: next edge gnt=0, state=IDLE.
  - In both release cases, ptr=owner+1 mod N.
  - Hold, req[owner]==1 and hold_cnt<MAX_HOLD-1 (or MAX_HOLD==0): gnt unchanged, hold_cnt++ (saturating when MAX_HOLD==0).
  - Timeout, req[owner]==1 and hold_cnt==MAX_HOLD-1:
    - Another request pending: preempt. gnt=pick(req & ~(1<<owner), owner+1), ptr=owner+1, owner_changed=1, hold_cnt=0.
    - Sole requester: keep the grant, hold_cnt=0, owner_changed=0.
- Same-edge events: a new request arriving on the owner's release edge competes normally in the handoff pick. A request that asserts and deasserts between edges is never seen.
- Wrap-around: ptr increments mod N. Owner N-1 releasing sets ptr=0.
- owner_changed is 0 on IDLE→GRANT and GRANT→IDLE transitions.
- Invariants:
  - $onehot0(gnt) on every cycle.
  - gnt_valid==|gnt on every cycle.
  - A granted bit always had its req high on the previous edge.

Decomposition:
- Shared package `arb_pkg`:
  - state typedef {IDLE, GRANT}.
  - Default N and MAX_HOLD constants.
  - Helper function `onehot_to_idx` for assertions and the bench.
- One combinational sub-module, `rr_pick`:
  - Parameter N.
  - Inputs req[N-1:0] and start[$clog2(N)-1:0]; output one-hot pick[N-1:0].
  - Instantiated once.
- Top module holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → gnt=0, gnt_valid=0 throughout; assert rst_n=0 while gnt=4'b0100 → gnt=0 asynchronously.
- req=4'b1010 from IDLE with ptr=0 → gnt=4'b0010 one cycle later; drop req[1] → next edge gnt=4'b1000, owner_changed=1 for one cycle, ptr=2.
- All four requesters held high, each releasing after 2 cycles of grant → grant order 0001, 0010, 0100, 1000, 0001 (wrap), no idle cycles between grants.
- MAX_HOLD=8, req=4'b0011 with bit0 never released → gnt=4'b0001 for exactly 8 cycles, then 4'b0010 with owner_changed=1.
- req=4'b0100 alone, held for 20 cycles with MAX_HOLD=8 → gnt stays 4'b0100, owner_changed stays 0, hold_cnt wraps at 7.
- Random req for 10k cycles with $onehot0(gnt) and fairness checks → no requester waits more than (N-1)*MAX_HOLD+N cycles; downstream encoder output always matches onehot_to_idx(gnt).
